// File: rtl/rpn_pkg.sv
// rpn_pkg: token kinds, opcodes, FSM state type and sizing helpers shared by
// the RPN evaluator, its interface and its operand stack.
package rpn_pkg;

    localparam logic [1:0] KIND_NUM = 2'd0;
    localparam logic [1:0] KIND_X   = 2'd1;
    localparam logic [1:0] KIND_OP  = 2'd2;
    localparam logic [1:0] KIND_END = 2'd3;

    localparam logic [2:0] OPC_ADD = 3'd0;
    localparam logic [2:0] OPC_SUB = 3'd1;
    localparam logic [2:0] OPC_MUL = 3'd2;
    localparam logic [2:0] OPC_DIV = 3'd3;
    localparam logic [2:0] OPC_POW = 3'd4;

    typedef enum logic [1:0] {
        ST_ACCEPT,
        ST_WAIT_OP,
        ST_FLUSH,
        ST_REPORT
    } state_t;

    function automatic logic is_local_op(input logic [2:0] opc);
        return (opc == OPC_ADD) || (opc == OPC_SUB);
    endfunction

    function automatic logic is_external_op(input logic [2:0] opc);
        return (opc == OPC_MUL) || (opc == OPC_DIV) || (opc == OPC_POW);
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rpn_evaluator_if.sv
// rpn_evaluator_if: token stream, external op-unit handshake and result report.
// slave is the evaluator's view; master is the token source / op unit view.
interface rpn_evaluator_if #(
    parameter int NUMBER_WIDTH = 8
);

    logic                    token_valid;
    logic                    token_ready;
    logic [1:0]              token_kind;
    logic [NUMBER_WIDTH-1:0] token_value;
    logic [NUMBER_WIDTH-1:0] x;

    logic                    op_start;
    logic [2:0]              op_code;
    logic [NUMBER_WIDTH-1:0] op_a;
    logic [NUMBER_WIDTH-1:0] op_b;
    logic                    op_done;
    logic [NUMBER_WIDTH-1:0] op_result;

    logic                    result_valid;
    logic [NUMBER_WIDTH-1:0] result;
    logic                    error;

    modport slave (
        input  token_valid, token_kind, token_value, x, op_done, op_result,
        output token_ready, op_start, op_code, op_a, op_b,
               result_valid, result, error
    );

    modport master (
        output token_valid, token_kind, token_value, x, op_done, op_result,
        input  token_ready, op_start, op_code, op_a, op_b,
               result_valid, result, error
    );

endinterface

// File: rtl/rpn_stack.sv
// rpn_stack: register-array operand stack with count, push, pop and replace-top.
// pop together with replace_top drops the top and overwrites the new top.
module rpn_stack
    import rpn_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 8,
    parameter int COUNT_WIDTH = count_width(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   replace_top,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       data_in,
    output logic [WIDTH-1:0]       top,
    output logic [WIDTH-1:0]       second,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int INDEX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]       entries [DEPTH];
    logic [COUNT_WIDTH-1:0] count_q;
    logic [INDEX_WIDTH-1:0] push_index;
    logic [INDEX_WIDTH-1:0] top_index;
    logic [INDEX_WIDTH-1:0] second_index;

    assign push_index   = INDEX_WIDTH'(count_q);
    assign top_index    = INDEX_WIDTH'(count_q - COUNT_WIDTH'(1));
    assign second_index = INDEX_WIDTH'(count_q - COUNT_WIDTH'(2));

    assign full   = (count_q == COUNT_WIDTH'(DEPTH));
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign top    = entries[top_index];
    assign second = entries[second_index];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (push && !full) begin
            count_q <= count_q + COUNT_WIDTH'(1);
        end else if (pop && !empty) begin
            count_q <= count_q - COUNT_WIDTH'(1);
        end
    end

    // Entry storage needs no reset: the count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            entries[push_index] <= data_in;
        end else if (replace_top && pop && !empty) begin
            entries[second_index] <= data_in;
        end else if (replace_top && !empty) begin
            entries[top_index] <= data_in;
        end
    end

endmodule

// File: rtl/rpn_evaluator.sv
// rpn_evaluator: token-stream RPN evaluator; add/sub local, mul/div/pow via external unit.
// Define RPN_EVALUATOR_SATURATE_EN for saturating add/sub instead of wrap-around.
module rpn_evaluator
    import rpn_pkg::*;
#(
    parameter int INTEGER_PART_WIDTH    = 5,
    parameter int FRACTIONAL_PART_WIDTH = 3,
    parameter int STACK_DEPTH           = 8
) (
    input logic            clk,
    input logic            rst_n,
    rpn_evaluator_if.slave bus
);

    localparam int NUMBER_WIDTH = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH;
    localparam int COUNT_WIDTH  = count_width(STACK_DEPTH);
    localparam int MSB          = NUMBER_WIDTH - 1;

    state_t state;
    state_t next_state;

    logic                    push;
    logic                    pop;
    logic                    replace_top;
    logic                    clear;
    logic [NUMBER_WIDTH-1:0] stack_data;
    logic [NUMBER_WIDTH-1:0] top_entry;
    logic [NUMBER_WIDTH-1:0] second_entry;
    logic [COUNT_WIDTH-1:0]  count;
    logic                    full;
    logic                    empty;
    logic                    has_two;

    logic                    dispatch;
    logic                    report;
    logic                    report_error;
    logic [NUMBER_WIDTH-1:0] report_value;

    logic [2:0]              opcode;
    logic                    is_sub;
    logic [NUMBER_WIDTH-1:0] alu_raw;
    logic [NUMBER_WIDTH-1:0] alu_result;

    logic                    op_start_q;
    logic [2:0]              op_code_q;
    logic [NUMBER_WIDTH-1:0] op_a_q;
    logic [NUMBER_WIDTH-1:0] op_b_q;
    logic                    result_valid_q;
    logic [NUMBER_WIDTH-1:0] result_q;
    logic                    error_q;

    rpn_stack #(
        .WIDTH       (NUMBER_WIDTH),
        .DEPTH       (STACK_DEPTH),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_stack (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .pop         (pop),
        .replace_top (replace_top),
        .clear       (clear),
        .data_in     (stack_data),
        .top         (top_entry),
        .second      (second_entry),
        .count       (count),
        .full        (full),
        .empty       (empty)
    );

    assign opcode  = bus.token_value[2:0];
    assign has_two = !empty && (count != COUNT_WIDTH'(1));
    assign is_sub  = (opcode == OPC_SUB);
    assign alu_raw = is_sub ? (second_entry - top_entry) : (second_entry + top_entry);

`ifdef RPN_EVALUATOR_SATURATE_EN
    localparam logic [NUMBER_WIDTH-1:0] MAX_POS = {1'b0, {(NUMBER_WIDTH-1){1'b1}}};
    localparam logic [NUMBER_WIDTH-1:0] MIN_NEG = {1'b1, {(NUMBER_WIDTH-1){1'b0}}};

    logic alu_overflow;

    // Overflow: result sign differs from a when the effective operand signs agree.
    assign alu_overflow = is_sub
        ? ((second_entry[MSB] != top_entry[MSB]) && (alu_raw[MSB] != second_entry[MSB]))
        : ((second_entry[MSB] == top_entry[MSB]) && (alu_raw[MSB] != second_entry[MSB]));
    assign alu_result = !alu_overflow ? alu_raw : (second_entry[MSB] ? MIN_NEG : MAX_POS);
`else
    assign alu_result = alu_raw;
`endif

    // Gated by rst_n so the evaluator never advertises readiness while held in reset.
    assign bus.token_ready  = rst_n && ((state == ST_ACCEPT) || (state == ST_FLUSH));
    assign bus.op_start     = op_start_q;
    assign bus.op_code      = op_code_q;
    assign bus.op_a         = op_a_q;
    assign bus.op_b         = op_b_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result       = result_q;
    assign bus.error        = error_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ACCEPT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        push         = 1'b0;
        pop          = 1'b0;
        replace_top  = 1'b0;
        clear        = 1'b0;
        stack_data   = alu_result;
        dispatch     = 1'b0;
        report       = 1'b0;
        report_error = 1'b0;
        report_value = '0;
        case (state)
            ST_ACCEPT: begin
                if (bus.token_valid) begin
                    case (bus.token_kind)
                        KIND_NUM, KIND_X: begin
                            stack_data = (bus.token_kind == KIND_X) ? bus.x : bus.token_value;
                            if (full) begin
                                next_state = ST_FLUSH;
                            end else begin
                                push = 1'b1;
                            end
                        end
                        KIND_OP: begin
                            if (!has_two || !(is_local_op(opcode) || is_external_op(opcode))) begin
                                next_state = ST_FLUSH;
                            end else if (is_local_op(opcode)) begin
                                pop         = 1'b1;
                                replace_top = 1'b1;
                            end else begin
                                dispatch   = 1'b1;
                                next_state = ST_WAIT_OP;
                            end
                        end
                        KIND_END: begin
                            report     = 1'b1;
                            next_state = ST_REPORT;
                            if (count == COUNT_WIDTH'(1)) begin
                                report_value = top_entry;
                            end else begin
                                report_error = 1'b1;
                            end
                        end
                    endcase
                end
            end
            ST_WAIT_OP: begin
                if (bus.op_done) begin
                    pop         = 1'b1;
                    replace_top = 1'b1;
                    stack_data  = bus.op_result;
                    next_state  = ST_ACCEPT;
                end
            end
            ST_FLUSH: begin
                if (bus.token_valid && (bus.token_kind == KIND_END)) begin
                    report       = 1'b1;
                    report_error = 1'b1;
                    next_state   = ST_REPORT;
                end
            end
            ST_REPORT: begin
                clear      = 1'b1;
                next_state = ST_ACCEPT;
            end
        endcase
    end

    // Operands and opcode stay latched after dispatch until the next dispatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_start_q     <= 1'b0;
            op_code_q      <= '0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            result_valid_q <= 1'b0;
            result_q       <= '0;
            error_q        <= 1'b0;
        end else begin
            op_start_q     <= dispatch;
            result_valid_q <= report;
            if (dispatch) begin
                op_code_q <= opcode;
                op_a_q    <= second_entry;
                op_b_q    <= top_entry;
            end
            if (report) begin
                result_q <= report_value;
                error_q  <= report_error;
            end
        end
    end

endmodule

// File: tb/tb_rpn_evaluator.sv
// tb_rpn_evaluator: directed plus randomized RPN expressions checked against a
// queue-based expression model; the bench also plays the external op unit.
module tb_rpn_evaluator;
    import rpn_pkg::*;

    localparam int NW    = 8;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] value;
        logic [7:0] xv;
    } tok_t;

    typedef struct packed {
        logic [2:0] code;
        logic [7:0] a;
        logic [7:0] b;
    } disp_t;

    typedef struct packed {
        logic [7:0] value;
        logic       err;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rpn_evaluator_if #(.NUMBER_WIDTH(NW)) bus ();

    rpn_evaluator #(
        .INTEGER_PART_WIDTH    (5),
        .FRACTIONAL_PART_WIDTH (3),
        .STACK_DEPTH           (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    tok_t  expr[$];
    disp_t exp_disp[$];
    res_t  exp_res[$];
    int    results_seen = 0;
    logic [7:0] last_result = '0;
    logic       last_error  = 1'b0;
    logic [2:0] last_code   = '0;
    logic [7:0] last_a      = '0;
    logic [7:0] last_b      = '0;
    int    op_delay = -1;
    bit    aborting = 1'b0;
    bit    mon_en   = 1'b0;
    logic  prev_start = 1'b0;
    logic  prev_valid = 1'b0;
    disp_t mon_d;
    res_t  mon_r;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Fixed-point Q5.3 reference for the external unit (any deterministic function serves).
    function automatic logic [7:0] extOp(input logic [2:0] code, input logic [7:0] a, input logic [7:0] b);
        int sa;
        int sb;
        int tmp;
        int e;
        logic [7:0] acc;
        sa = int'($signed(a));
        sb = int'($signed(b));
        acc = 8'h08;
        if (code == OPC_MUL) begin
            tmp = (sa * sb) >>> 3;
            acc = tmp[7:0];
        end else if (code == OPC_DIV) begin
            tmp = (sb == 0) ? 127 : (sa * 8) / sb;
            acc = tmp[7:0];
        end else begin
            e = sb >>> 3;
            if (e < 0) begin
                acc = 8'h00;
            end else begin
                for (int i = 0; i < e; i++) begin
                    tmp = (int'($signed(acc)) * sa) >>> 3;
                    acc = tmp[7:0];
                end
            end
        end
        return acc;
    endfunction

    function automatic logic [7:0] addSub(input logic [7:0] a, input logic [7:0] b, input bit sub);
        int s;
        s = sub ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
`ifdef RPN_EVALUATOR_SATURATE_EN
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
`endif
        return s[7:0];
    endfunction

    // Evaluate the whole queued expression and queue up every observable it must produce.
    function automatic void modelEval(output logic [7:0] r, output logic er);
        logic [7:0] st[$];
        bit         flush;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] opc;
        tok_t       t;
        flush = 1'b0;
        r     = '0;
        er    = 1'b1;
        foreach (expr[i]) begin
            t = expr[i];
            if (t.kind == KIND_END) begin
                if (!flush && st.size() == 1) begin
                    r  = st[0];
                    er = 1'b0;
                end else begin
                    r  = '0;
                    er = 1'b1;
                end
                exp_res.push_back('{r, er});
                return;
            end
            if (!flush) begin
                if (t.kind == KIND_NUM || t.kind == KIND_X) begin
                    if (st.size() >= DEPTH) flush = 1'b1;
                    else st.push_back((t.kind == KIND_X) ? t.xv : t.value);
                end else begin
                    opc = t.value[2:0];
                    if (opc > 3'd4 || st.size() < 2) begin
                        flush = 1'b1;
                    end else begin
                        b = st.pop_back();
                        a = st.pop_back();
                        if (opc == OPC_ADD || opc == OPC_SUB) begin
                            st.push_back(addSub(a, b, opc == OPC_SUB));
                        end else begin
                            exp_disp.push_back('{opc, a, b});
                            st.push_back(extOp(opc, a, b));
                        end
                    end
                end
            end
        end
    endfunction

    task automatic addTok(input logic [1:0] kind, input logic [7:0] value, input logic [7:0] xv);
        tok_t t;
        t.kind  = kind;
        t.value = value;
        t.xv    = xv;
        expr.push_back(t);
    endtask

    task automatic sendToken(input tok_t t);
        int guard;
        guard = 0;
        bus.token_valid = 1'b1;
        bus.token_kind  = t.kind;
        bus.token_value = t.value;
        bus.x           = t.xv;
        while (!bus.token_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            total++;
            bad++;
            $display("[TB] FAIL token_ready_timeout: ready=%0b required=1 after %0d cycles", bus.token_ready, guard);
        end
        @(negedge clk);
        bus.token_valid = 1'b0;
    endtask

    task automatic applyStimulus(output logic [7:0] mr, output logic me);
        int target;
        int guard;
        modelEval(mr, me);
        target = results_seen + 1;
        foreach (expr[i]) begin
            sendToken(expr[i]);
            if ($urandom_range(0, 4) == 0) @(negedge clk);
        end
        guard = 0;
        while (results_seen < target && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (results_seen < target) begin
            total++;
            bad++;
            $display("[TB] FAIL result_timeout: results_seen=%0d required=%0d", results_seen, target);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_token_ready"},  32'(bus.token_ready),  32'h0);
        checkOutput({tag, "_op_start"},     32'(bus.op_start),     32'h0);
        checkOutput({tag, "_op_code"},      32'(bus.op_code),      32'h0);
        checkOutput({tag, "_op_a"},         32'(bus.op_a),         32'h0);
        checkOutput({tag, "_op_b"},         32'(bus.op_b),         32'h0);
        checkOutput({tag, "_result_valid"}, 32'(bus.result_valid), 32'h0);
        checkOutput({tag, "_result"},       32'(bus.result),       32'h0);
        checkOutput({tag, "_error"},        32'(bus.error),        32'h0);
    endtask

    task automatic genRandom();
        tok_t t;
        int   depth;
        int   len;
        bit   wild;
        depth = 0;
        len   = $urandom_range(1, 14);
        wild  = ($urandom_range(0, 9) == 0);
        expr.delete();
        for (int i = 0; i < len; i++) begin
            t.xv    = 8'($urandom);
            t.value = 8'($urandom);
            if (wild) begin
                t.kind = 2'($urandom_range(0, 2));
            end else if (depth < 2 || $urandom_range(0, 9) < 4) begin
                t.kind = ($urandom_range(0, 1) == 1) ? KIND_X : KIND_NUM;
                depth++;
            end else begin
                t.kind       = KIND_OP;
                t.value[2:0] = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
                depth--;
            end
            expr.push_back(t);
        end
        addTok(KIND_END, 8'($urandom), 8'($urandom));
    endtask

    // Every cycle: op_start and result_valid pulses are matched against the model queues.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (bus.op_start) begin
                last_code = bus.op_code;
                last_a    = bus.op_a;
                last_b    = bus.op_b;
                checkOutput("op_start_pulse", 32'(prev_start), 32'h0);
                if (exp_disp.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL op_start_unexpected: op_code=%0d required no dispatch", bus.op_code);
                end else begin
                    mon_d = exp_disp.pop_front();
                    checkOutput("op_code", 32'(bus.op_code), 32'(mon_d.code));
                    checkOutput("op_a",    32'(bus.op_a),    32'(mon_d.a));
                    checkOutput("op_b",    32'(bus.op_b),    32'(mon_d.b));
                end
            end
            if (bus.result_valid) begin
                last_result = bus.result;
                last_error  = bus.error;
                checkOutput("result_valid_pulse", 32'(prev_valid), 32'h0);
                checkOutput("ready_in_report",    32'(bus.token_ready), 32'h0);
                if (exp_res.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL result_unexpected: result=0x%0h required no result", bus.result);
                end else begin
                    mon_r = exp_res.pop_front();
                    checkOutput("result", 32'(bus.result), 32'(mon_r.value));
                    checkOutput("error",  32'(bus.error),  32'(mon_r.err));
                end
                results_seen++;
            end
        end
        prev_start = bus.op_start;
        prev_valid = bus.result_valid;
    end

    // External op unit: answers each op_start after a programmable or random delay.
    initial begin
        logic [2:0] code;
        logic [7:0] a;
        logic [7:0] b;
        int         dly;
        bus.op_done   = 1'b0;
        bus.op_result = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.op_start) begin
                code = bus.op_code;
                a    = bus.op_a;
                b    = bus.op_b;
                dly  = (op_delay < 0) ? int'($urandom_range(0, 4)) : op_delay;
                repeat (dly) @(negedge clk);
                if (!aborting) begin
                    checkOutput("op_a_held", 32'(bus.op_a), 32'(a));
                    checkOutput("op_b_held", 32'(bus.op_b), 32'(b));
                end
                bus.op_done   = 1'b1;
                bus.op_result = extOp(code, a, b);
                @(negedge clk);
                bus.op_done   = 1'b0;
                bus.op_result = 8'($urandom);
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] mr;
        logic       me;
        bus.token_valid = 1'b0;
        bus.token_kind  = KIND_NUM;
        bus.token_value = '0;
        bus.x           = '0;

        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_release", 32'(bus.token_ready), 32'h1);

        expr.delete();
        addTok(KIND_NUM, 8'h10, 8'h00);
        addTok(KIND_NUM, 8'h18, 8'h00);
        addTok(KIND_OP,  {5'd0, OPC_ADD}, 8'h00);
        addTok(KIND_END, 8'h00, 8'h00);
        applyStimulus(mr, me);
        checkOutput("add_model",      32'(mr),          32'h28);
        checkOutput("add_dut_result", 32'(last_result), 32'h28);
        checkOutput("add_dut_error",  32'(last_error),  32'h0);

        expr.delete();
        addTok(KIND_X,   8'h00, 8'h0C);
        addTok(KIND_NUM, 8'h10, 8'h00);
        addTok(KIND_OP,  {5'd0, OPC_SUB}, 8'h00);
        addTok(KIND_END, 8'h00, 8'h00);
        applyStimulus(mr, me);
        checkOutput("sub_model",      32'(mr),          32'hFC);
        checkOutput("sub_dut_result", 32'(last_result), 32'hFC);

        op_delay = 5;
        expr.delete();
        addTok(KIND_NUM, 8'h10, 8'h00);
        addTok(KIND_NUM, 8'h18, 8'h00);
        addTok(KIND_OP,  {5'd0, OPC_POW}, 8'h00);
        addTok(KIND_END, 8'h00, 8'h00);
        applyStimulus(mr, me);
        op_delay = -1;
        checkOutput("pow_model",      32'(mr),          32'h40);
        checkOutput("pow_op_code",    32'(last_code),   32'h4);
        checkOutput("pow_op_a",       32'(last_a),      32'h10);
        checkOutput("pow_op_b",       32'(last_b),      32'h18);
        checkOutput("pow_dut_result", 32'(last_result), 32'h40);

        expr.delete();
        addTok(KIND_NUM, 8'h08, 8'h00);
        addTok(KIND_OP,  {5'd0, OPC_ADD}, 8'h00);
        addTok(KIND_NUM, 8'h08, 8'h00);
        addTok(KIND_END, 8'h00, 8'h00);
        applyStimulus(mr, me);
        checkOutput("underflow_error",  32'(last_error),  32'h1);
        checkOutput("underflow_result", 32'(last_result), 32'h0);

        expr.delete();
        addTok(KIND_NUM, 8'h20, 8'h00);
        addTok(KIND_END, 8'h00, 8'h00);
        applyStimulus(mr, me);
        checkOutput("after_error_result", 32'(last_result), 32'h20);
        checkOutput("after_error_error",  32'(last_error),  32'h0);

        expr.delete();
        for (int i = 0; i < 9; i++) addTok(KIND_NUM, 8'(i * 8), 8'h00);
        addTok(KIND_END, 8'h00, 8'h00);
        applyStimulus(mr, me);
        checkOutput("overflow_error", 32'(last_error), 32'h1);

        expr.delete();
        addTok(KIND_NUM, 8'h78, 8'h00);
        addTok(KIND_NUM, 8'h10, 8'h00);
        addTok(KIND_OP,  {5'd0, OPC_ADD}, 8'h00);
        addTok(KIND_END, 8'h00, 8'h00);
        applyStimulus(mr, me);
`ifdef RPN_EVALUATOR_SATURATE_EN
        checkOutput("wrap_or_sat_result", 32'(last_result), 32'h7F);
`else
        checkOutput("wrap_or_sat_result", 32'(last_result), 32'h88);
`endif

        // Reset while the external unit is busy; its late op_done must be ignored.
        aborting = 1'b1;
        op_delay = 8;
        exp_disp.push_back('{OPC_MUL, 8'h10, 8'h18});
        expr.delete();
        addTok(KIND_NUM, 8'h10, 8'h00);
        addTok(KIND_NUM, 8'h18, 8'h00);
        addTok(KIND_OP,  {5'd0, OPC_MUL}, 8'h00);
        foreach (expr[i]) sendToken(expr[i]);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkResetValues("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        aborting = 1'b0;
        op_delay = -1;
        expr.delete();
        addTok(KIND_NUM, 8'h08, 8'h00);
        addTok(KIND_END, 8'h00, 8'h00);
        applyStimulus(mr, me);
        checkOutput("post_abort_result", 32'(last_result), 32'h08);
        checkOutput("post_abort_error",  32'(last_error),  32'h0);

        for (int n = 0; n < 40; n++) begin
            genRandom();
            applyStimulus(mr, me);
        end

        repeat (3) @(negedge clk);
        checkOutput("pending_results",    32'(exp_res.size()),  32'h0);
        checkOutput("pending_dispatches", 32'(exp_disp.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rpn_evaluator.md
# rpn_evaluator

Sequential reverse-Polish expression evaluator that drives the fixed-point arithmetic units of the function plotter. It consumes a token stream, keeps a stack of signed Q(INTEGER_PART_WIDTH).(FRACTIONAL_PART_WIDTH) values, and computes add/sub locally. It dispatches mul/div/pow to an external op unit over the start/done handshake used by fixed_point_pow, then reports one result per expression.

## Interface
- INTEGER_PART_WIDTH, 5, integer bits of the fixed-point format
- FRACTIONAL_PART_WIDTH, 3, fractional bits; NUMBER_WIDTH = sum
- STACK_DEPTH, 8, maximum stack entries (≥2)

Ports:
- clk  in  1  clock; everything on posedge
- rst_n  in  1  reset, asynchronous, active-low
- token_valid  in  1  token present
- token_ready  out  1  evaluator accepts token this cycle
- token_kind  in  2  0 NUM, 1 X, 2 OP, 3 END
- token_value  in  NUMBER_WIDTH  constant (NUM) or opcode in bits [2:0] (OP)
- x  in  NUMBER_WIDTH  current abscissa, sampled when X token accepted
- op_start  out  1  one-cycle pulse to external unit
- op_code  out  3  2 MUL, 3 DIV, 4 POW
- op_a, op_b  out  NUMBER_WIDTH  operands (a = deeper entry), held stable from op_start until op_done
- op_done  in  1  external unit finished
- op_result  in  NUMBER_WIDTH  valid when op_done
- result_valid  out  1  one-cycle pulse, end of expression
- result  out  NUMBER_WIDTH  final value (0 on error)
- error  out  1  qualified by result_valid

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 POW, 5–7 invalid.
- States: ACCEPT, WAIT_OP, FLUSH, REPORT.
- ACCEPT (token_ready=1), on accepted token:
  - NUM/X: push; stack full → FLUSH (overflow).
  - ADD/SUB: need count≥2, else FLUSH (underflow); pop b, pop a, push a±b; stay ACCEPT.
  - MUL/DIV/POW: need count≥2, else FLUSH; latch op_a/op_b/op_code, pulse op_start next cycle → WAIT_OP.
  - invalid opcode → FLUSH.
  - END: count==1 → REPORT with top, error=0; otherwise → REPORT with error=1.
- WAIT_OP (token_ready=0): on op_done, replace the two operands with op_result (count−1) → ACCEPT. op_done outside WAIT_OP is ignored.
- FLUSH (token_ready=1): discard tokens until END, then REPORT with error=1.
- REPORT: result_valid=1 for one cycle; stack cleared; → ACCEPT. token_ready=0.
- Arithmetic: ADD/SUB on NUMBER_WIDTH two's complement, wrap-around (see Configuration). No width growth.

## Timing
- Reset values: token_ready=0 during reset, 1 from first cycle after release; op_start=0, op_code=0, op_a=op_b=0, result_valid=0, result=0, error=0; state ACCEPT, count 0.
- NUM/X/ADD/SUB: 1 token per cycle, back-to-back.
- Dispatch: token accepted at edge N → op_start high cycle N+1 → op_done at edge M → token_ready high in cycle M+1.
- END accepted at edge N → result_valid high in cycle N+1; token_ready low that cycle.
- Reset mid-WAIT_OP: abandon op; the external unit's later op_done is ignored.

## Configuration
- RPN_EVALUATOR_SATURATE_EN defined: ADD/SUB saturate to max positive (0111…1) / min negative (1000…0) on overflow.
- Undefined: ADD/SUB wrap modulo 2^NUMBER_WIDTH.

## Structure
- Package rpn_pkg: token_kind constants, opcode constants, state enum.
- Sub-module rpn_stack: register-array stack with count, push/pop/replace-top, exposes top and second entry, full/empty flags.

## Test plan
- NUM 0x10, NUM 0x18, OP ADD, END → result 0x28, error 0, one result_valid pulse.
- x=0x0C; X, NUM 0x10, OP SUB, END → result 0xFC (−0.5).
- NUM 0x10, NUM 0x18, OP POW → op_start one cycle, op_code 4, op_a 0x10, op_b 0x18 held; bench returns op_done + 0x40 after 5 cycles; END → result 0x40.
- NUM 0x08, OP ADD, NUM 0x08, END → error 1, result 0; following 2-token expression evaluates correctly.
- 9× NUM with STACK_DEPTH=8, END → error 1. NUM 0x78, NUM 0x10, ADD, END → 0x88 without macro, 0x7F with RPN_EVALUATOR_SATURATE_EN.
- rst_n low during WAIT_OP → all outputs at reset values; late op_done ignored; next expression correct.
